// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU types: producing-unit encoding and flag bit positions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        UNIT_AB  = 2'd0,
        UNIT_LB  = 2'd1,
        UNIT_LSB = 2'd2,
        UNIT_RSB = 2'd3
    } alu_unit_e;

    localparam int FLAGS_WIDTH = 5;

    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_SF = 3;
    localparam int FLAG_PF = 4;

endpackage

`default_nettype wire

// File: rtl/result_fifo2.sv
// ============================================================================
// Module : result_fifo2
// Brief  : Two-entry valid/ready queue with registered outputs, no bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_fifo2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o
);

    logic [1:0]            count_q,  count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  push;
    logic                  pop;

    // Ready comes from the count alone so it never depends on pop_ready_i.
    assign push_ready_o = (count_q != 2'd2);
    assign pop_valid_o  = (count_q != 2'd0);
    assign pop_data_o   = mem_q[rd_ptr_q];

    always_comb begin
        push     = push_valid_i & push_ready_o;
        pop      = pop_valid_o & pop_ready_i;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module : alu_result_stage
// Brief  : Selects the producing ALU block's result, owns the architectural
//          flags register and queues results toward register writeback.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int DEST_WIDTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [1:0]             unit_i,
    input  logic [DEST_WIDTH-1:0]  dest_i,
    input  logic                   flags_we_i,
    input  logic [WORD_WIDTH-1:0]  AB_r_i,
    input  logic [WORD_WIDTH-1:0]  LB_r_i,
    input  logic [WORD_WIDTH-1:0]  LSB_r_i,
    input  logic [WORD_WIDTH-1:0]  RSB_r_i,
    input  logic [FLAGS_WIDTH-1:0] alu_flags_i,
    input  logic                   flags_load_i,
    input  logic [FLAGS_WIDTH-1:0] flags_data_i,
    output logic [FLAGS_WIDTH-1:0] flags_o,
    output logic                   cf_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WORD_WIDTH-1:0]  out_r_o,
    output logic [DEST_WIDTH-1:0]  out_dest_o
);

    localparam int PAYLOAD_WIDTH = WORD_WIDTH + DEST_WIDTH;

    logic [WORD_WIDTH-1:0]    result_mux;
    logic [FLAGS_WIDTH-1:0]   flags_q, flags_d;
    logic                     accept;
    logic [PAYLOAD_WIDTH-1:0] head_payload;

    always_comb begin
        result_mux = AB_r_i;
        case (alu_unit_e'(unit_i))
            UNIT_AB:  result_mux = AB_r_i;
            UNIT_LB:  result_mux = LB_r_i;
            UNIT_LSB: result_mux = LSB_r_i;
            UNIT_RSB: result_mux = RSB_r_i;
            default:  result_mux = AB_r_i;
        endcase
    end

    // A direct restore overrides any flag write from an op accepted the same cycle.
    always_comb begin
        accept  = in_valid_i & in_ready_o;
        flags_d = flags_q;
        if (flags_load_i) begin
            flags_d = flags_data_i;
        end else if (accept && flags_we_i) begin
            flags_d = alu_flags_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Flags come straight from the register so the ALU carry loop stays broken.
    assign flags_o = flags_q;
    assign cf_o    = flags_q[FLAG_CF];

    result_fifo2 #(
        .DATA_WIDTH (PAYLOAD_WIDTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_valid_i (in_valid_i),
        .push_ready_o (in_ready_o),
        .push_data_i  ({result_mux, dest_i}),
        .pop_valid_o  (out_valid_o),
        .pop_ready_i  (out_ready_i),
        .pop_data_o   (head_payload)
    );

    assign out_r_o    = head_payload[PAYLOAD_WIDTH-1:DEST_WIDTH];
    assign out_dest_o = head_payload[DEST_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module : tb_alu_result_stage
// Brief  : Directed self-checking bench for alu_result_stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  unit_i;
    logic [2:0]  dest_i;
    logic        flags_we_i;
    logic [15:0] AB_r_i, LB_r_i, LSB_r_i, RSB_r_i;
    logic [4:0]  alu_flags_i;
    logic        flags_load_i;
    logic [4:0]  flags_data_i;
    logic [4:0]  flags_o;
    logic        cf_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_r_o;
    logic [2:0]  out_dest_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    alu_result_stage #(
        .WORD_WIDTH (16),
        .DEST_WIDTH (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .unit_i       (unit_i),
        .dest_i       (dest_i),
        .flags_we_i   (flags_we_i),
        .AB_r_i       (AB_r_i),
        .LB_r_i       (LB_r_i),
        .LSB_r_i      (LSB_r_i),
        .RSB_r_i      (RSB_r_i),
        .alu_flags_i  (alu_flags_i),
        .flags_load_i (flags_load_i),
        .flags_data_i (flags_data_i),
        .flags_o      (flags_o),
        .cf_o         (cf_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_r_o      (out_r_o),
        .out_dest_o   (out_dest_o)
    );

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        in_valid_i   = 1'b1;
        unit_i       = 2'd0;
        dest_i       = 3'd5;
        flags_we_i   = 1'b1;
        AB_r_i       = 16'hDEAD;
        LB_r_i       = 16'h0000;
        LSB_r_i      = 16'h0000;
        RSB_r_i      = 16'h0000;
        alu_flags_i  = 5'b11111;
        flags_load_i = 1'b0;
        flags_data_i = 5'b00000;
        out_ready_i  = 1'b0;
        step();
        step();
        total++;
        if (flags_o !== 5'b00000) $display("FAIL reset_flags: got %b want %b", flags_o, 5'b00000);
        else passed++;
        total++;
        if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid_o);
        else passed++;
        total++;
        if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready_o);
        else passed++;
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        flags_we_i = 1'b0;
        step();
        total++;
        if (out_valid_o !== 1'b0) $display("FAIL reset_nothing_enqueued: out_valid got %b want 0", out_valid_o);
        else passed++;
    endtask

    task automatic test_unit_select();
        logic [1:0]  units [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
        logic [15:0] exp_r [4] = '{16'h00F0, 16'h1234, 16'h5A5A, 16'h8001};
        logic [2:0]  dests [4] = '{3'd3, 3'd1, 3'd6, 3'd7};
        AB_r_i  = 16'h1234;
        LB_r_i  = 16'h5A5A;
        LSB_r_i = 16'h00F0;
        RSB_r_i = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            unit_i      = units[i];
            dest_i      = dests[i];
            in_valid_i  = 1'b1;
            out_ready_i = 1'b0;
            step();
            in_valid_i = 1'b0;
            total++;
            if (out_valid_o !== 1'b1 || out_r_o !== exp_r[i] || out_dest_o !== dests[i])
                $display("FAIL unit_select_%0d: got v=%b r=%h d=%0d want v=1 r=%h d=%0d",
                         units[i], out_valid_o, out_r_o, out_dest_o, exp_r[i], dests[i]);
            else passed++;
            out_ready_i = 1'b1;
            step();
            out_ready_i = 1'b0;
            total++;
            if (out_valid_o !== 1'b0) $display("FAIL unit_drain_%0d: out_valid got %b want 0", units[i], out_valid_o);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        unit_i      = 2'd0;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        AB_r_i = 16'hAAAA; dest_i = 3'd1;
        step();
        total++;
        if (in_ready_o !== 1'b1) $display("FAIL bp_ready_after_A: got %b want 1", in_ready_o);
        else passed++;
        AB_r_i = 16'hBBBB; dest_i = 3'd2;
        step();
        total++;
        if (in_ready_o !== 1'b0) $display("FAIL bp_full_after_B: got %b want 0", in_ready_o);
        else passed++;
        AB_r_i = 16'hCCCC; dest_i = 3'd3;
        step();
        total++;
        if (in_ready_o !== 1'b0 || out_r_o !== 16'hAAAA || out_dest_o !== 3'd1)
            $display("FAIL bp_hold_C: got rdy=%b r=%h d=%0d want rdy=0 r=aaaa d=1", in_ready_o, out_r_o, out_dest_o);
        else passed++;
        out_ready_i = 1'b1;
        step();
        total++;
        if (out_valid_o !== 1'b1 || out_r_o !== 16'hBBBB || out_dest_o !== 3'd2)
            $display("FAIL bp_second_B: got v=%b r=%h d=%0d want v=1 r=bbbb d=2", out_valid_o, out_r_o, out_dest_o);
        else passed++;
        step();
        in_valid_i = 1'b0;
        total++;
        if (out_valid_o !== 1'b1 || out_r_o !== 16'hCCCC || out_dest_o !== 3'd3)
            $display("FAIL bp_third_C: got v=%b r=%h d=%0d want v=1 r=cccc d=3", out_valid_o, out_r_o, out_dest_o);
        else passed++;
        step();
        total++;
        if (out_valid_o !== 1'b0) $display("FAIL bp_no_duplicate: out_valid got %b want 0", out_valid_o);
        else passed++;
        out_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        unit_i      = 2'd1;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b0;
        LB_r_i      = 16'h0100;
        dest_i      = 3'd0;
        step();
        out_ready_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            LB_r_i = 16'h0100 + 16'(i);
            dest_i = 3'(i);
            step();
            total++;
            if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1 || out_r_o !== 16'h0100 + 16'(i) || out_dest_o !== 3'(i))
                $display("FAIL b2b_cycle_%0d: got v=%b rdy=%b r=%h d=%0d want v=1 rdy=1 r=%h d=%0d",
                         i, out_valid_o, in_ready_o, out_r_o, out_dest_o, 16'h0100 + 16'(i), 3'(i));
            else passed++;
        end
        in_valid_i = 1'b0;
        step();
        total++;
        if (out_valid_o !== 1'b0) $display("FAIL b2b_drain: out_valid got %b want 0", out_valid_o);
        else passed++;
        out_ready_i = 1'b0;
    endtask

    task automatic test_flags();
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        flags_we_i  = 1'b1;
        alu_flags_i = 5'b00011;
        step();
        in_valid_i = 1'b0;
        total++;
        if (flags_o !== 5'b00011 || cf_o !== 1'b1)
            $display("FAIL flags_write: got %b cf=%b want 00011 cf=1", flags_o, cf_o);
        else passed++;
        in_valid_i  = 1'b1;
        flags_we_i  = 1'b0;
        alu_flags_i = 5'b11100;
        step();
        in_valid_i = 1'b0;
        total++;
        if (flags_o !== 5'b00011) $display("FAIL flags_hold_we0: got %b want 00011", flags_o);
        else passed++;
        flags_load_i = 1'b1;
        flags_data_i = 5'b01000;
        step();
        flags_load_i = 1'b0;
        total++;
        if (flags_o !== 5'b01000 || cf_o !== 1'b0)
            $display("FAIL flags_direct_load: got %b cf=%b want 01000 cf=0", flags_o, cf_o);
        else passed++;
        step();
        out_ready_i = 1'b0;
    endtask

    task automatic test_flag_priority();
        flags_load_i = 1'b1;
        flags_data_i = 5'b10000;
        in_valid_i   = 1'b1;
        flags_we_i   = 1'b1;
        alu_flags_i  = 5'b00001;
        out_ready_i  = 1'b0;
        step();
        flags_load_i = 1'b0;
        flags_we_i   = 1'b0;
        total++;
        if (flags_o !== 5'b10000 || cf_o !== 1'b0)
            $display("FAIL flags_priority: got %b cf=%b want 10000 cf=0", flags_o, cf_o);
        else passed++;
        step();
        in_valid_i = 1'b0;
        total++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1)
            $display("FAIL prio_queue_full: got rdy=%b v=%b want rdy=0 v=1", in_ready_o, out_valid_o);
        else passed++;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || flags_o !== 5'b00000)
            $display("FAIL midqueue_reset: got v=%b rdy=%b flags=%b want v=0 rdy=1 flags=00000",
                     out_valid_o, in_ready_o, flags_o);
        else passed++;
        step();
        total++;
        if (out_valid_o !== 1'b0) $display("FAIL midqueue_reset_stays_empty: got %b want 0", out_valid_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_unit_select();
        test_backpressure();
        test_back_to_back();
        test_flags();
        test_flag_priority();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
